// File: rtl/vc_input_buffer.sv
// Virtual-channel input buffer: one circular FIFO per VC, combinational head, registered credit return.
// Define VC_INPUT_BUFFER_CREDIT_BATCH_EN to batch credits per VC instead of one pulse per pop.
module vc_input_buffer #(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_WIDTH  = 32,
    localparam int VC_W       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                in_valid,
    input  logic [FLIT_WIDTH-1:0]               in_flit,
    input  logic [VC_W-1:0]                     in_vc,
    input  logic [NUM_VCS-1:0]                  pop,
    output logic [NUM_VCS-1:0][FLIT_WIDTH-1:0]  head,
    output logic [NUM_VCS-1:0]                  empty,
    output logic [NUM_VCS-1:0]                  credit_out,
    output logic                                overflow_err
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

    logic [NUM_VCS-1:0] drop;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        logic [FLIT_WIDTH-1:0] mem [BUFFER_SIZE];
        logic [PTR_W-1:0]      rd_ptr;
        logic [PTR_W-1:0]      wr_ptr;
        logic [CNT_W-1:0]      count;
        logic                  credit_q;
        logic                  is_empty;
        logic                  is_full;
        logic                  push_req;
        logic                  pop_ok;
        logic                  push_ok;

        assign is_empty = (count == '0);
        assign is_full  = (count == FULL_CNT);
        assign push_req = in_valid && (in_vc == VC_W'(v));
        assign pop_ok   = pop[v] && !is_empty;
        // A full FIFO still accepts a push when the same cycle frees the head slot.
        assign push_ok  = push_req && (!is_full || pop_ok);
        assign drop[v]  = push_req && is_full && !pop_ok;

        assign empty[v]      = is_empty;
        assign head[v]       = is_empty ? '0 : mem[rd_ptr];
        assign credit_out[v] = credit_q;

        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem[wr_ptr] <= in_flit;
            end
        end

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                end
                if (push_ok && !pop_ok) begin
                    count <= count + CNT_W'(1);
                end else if (pop_ok && !push_ok) begin
                    count <= count - CNT_W'(1);
                end
            end
        end

`ifdef VC_INPUT_BUFFER_CREDIT_BATCH_EN
        localparam int BATCH_T = ((3 * BUFFER_SIZE) / 4 < 1) ? 1 : (3 * BUFFER_SIZE) / 4;
        localparam int BATCH_W = $clog2(BATCH_T + 1);
        localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(BATCH_T - 1);

        logic [BATCH_W-1:0] batch_cnt;

        // Partial batches are held indefinitely; only a completed batch returns credit.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                batch_cnt <= '0;
                credit_q  <= 1'b0;
            end else if (pop_ok) begin
                if (batch_cnt == BATCH_LAST) begin
                    batch_cnt <= '0;
                    credit_q  <= 1'b1;
                end else begin
                    batch_cnt <= batch_cnt + BATCH_W'(1);
                    credit_q  <= 1'b0;
                end
            end else begin
                credit_q <= 1'b0;
            end
        end
`else
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                credit_q <= 1'b0;
            end else begin
                credit_q <= pop_ok;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_err <= 1'b0;
        end else if (|drop) begin
            overflow_err <= 1'b1;
        end
    end

endmodule
